reg_writeback: RTL

- Producer side of the per-thread register file write port. Collects results from the ALU (fixed latency, no backpressure) and the LSU (variable latency, valid/ready) and serialises them onto the single write_enable/write_addr/write_data port.
- Keeps a load scoreboard so issue logic can stall on registers with outstanding loads.
- One instance per thread lane, sitting between the execute units and the register file.

---
 rtl/gpu_pkg.sv | 26 ++
 rtl/reg_writeback_if.sv | 21 ++
 rtl/wb_fifo.sv | 60 ++++++
 rtl/reg_writeback.sv | 125 ++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared constants and the write-back entry type for the register write port.
// Imported by the LSU interface, the response FIFO and reg_writeback.
package gpu_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;
  localparam int NUM_GPR  = 13;
  localparam int NUM_REGS = 1 << ADDR_W;

  // First read-only register; everything at or above it is read-only.
  localparam logic [ADDR_W-1:0] REG_BLOCK_ID  = ADDR_W'(NUM_GPR);
  localparam logic [ADDR_W-1:0] REG_TPB       = 4'd14;
  localparam logic [ADDR_W-1:0] REG_THREAD_ID = 4'd15;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic is_gpr(
    input logic [ADDR_W-1:0] a
  );
    return a < REG_BLOCK_ID;
  endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// LSU response channel: valid/ready handshake carrying {rd, data}.
// master = LSU (drives valid/rd/data), slave = reg_writeback (drives ready).
interface reg_writeback_if;
  import gpu_pkg::*;

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] data;

  modport master (
    output valid, rd, data,
    input  ready
  );

  modport slave (
    input  valid, rd, data,
    output ready
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_entry_t buffering LSU responses.
// Ports: clk, reset, push/din, pop/dout, full, empty, count.
module wb_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  wb_entry_t     din,
  input  logic          pop,
  output wb_entry_t     dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  wb_entry_t         mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Serialises ALU and LSU results onto the register file write port and
// tracks outstanding loads. Ports: clk/reset, ALU result, ld_issue/ld_rd,
// LSU channel (lsu), registered write port, query_addr1-3, busy/ro_err/idle.
module reg_writeback
  import gpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_issue,
  input  logic [ADDR_W-1:0] ld_rd,
  reg_writeback_if.slave    lsu,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] query_addr1,
  input  logic [ADDR_W-1:0] query_addr2,
  input  logic [ADDR_W-1:0] query_addr3,
  output logic              busy,
  output logic              ro_err,
  output logic              idle
);

  wb_entry_t            head;
  wb_entry_t            lsu_e;
  wb_entry_t            sel;
  logic                 sel_valid;
  logic                 sel_ok;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;
  logic [NUM_GPR-1:0]   sb;
  logic [NUM_GPR-1:0]   set_m;
  logic [NUM_GPR-1:0]   clr_m;
  logic [NUM_REGS-1:0]  sb_ext;

  // Ready depends on the current count only: a full FIFO never
  // accepts, even in a cycle where it pops.
  assign lsu.ready = !fifo_full;
  assign push      = lsu.valid && lsu.ready;
  assign lsu_e     = '{rd: lsu.rd, data: lsu.data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (lsu_e),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ALU has strict priority; the FIFO head only moves when ALU is idle.
  always_comb begin
    sel       = '{rd: alu_rd, data: alu_data};
    sel_valid = 1'b0;
    pop       = 1'b0;
    priority case (1'b1)
      alu_valid: begin
        sel_valid = 1'b1;
      end
      !fifo_empty: begin
        sel       = head;
        sel_valid = 1'b1;
        pop       = 1'b1;
      end
      default: ;
    endcase
  end

  assign sel_ok = is_gpr(sel.rd);

  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (ld_issue && is_gpr(ld_rd)) begin
      set_m = NUM_GPR'(1) << ld_rd;
    end
    if (pop && is_gpr(head.rd)) begin
      clr_m = NUM_GPR'(1) << head.rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb           <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      ro_err       <= 1'b0;
    end else begin
      // Set after clear: a newer load to the same register stays pending.
      sb           <= (sb & ~clr_m) | set_m;
      write_enable <= sel_valid && sel_ok;
      ro_err       <= sel_valid && !sel_ok;
      if (sel_valid && sel_ok) begin
        write_addr <= sel.rd;
        write_data <= sel.data;
      end
    end
  end

  // Zero-extended so read-only addresses index a constant 0.
  assign sb_ext = NUM_REGS'(sb);
  assign busy   = sb_ext[query_addr1]
               | sb_ext[query_addr2]
               | sb_ext[query_addr3];

  assign idle = (sb == '0)
             && (fifo_count == '0)
             && fifo_empty
             && !write_enable;

endmodule
